// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit front end.
// Holds the frame width, parity encodings, FSM state type, per-frame
// configuration struct and the single-cycle frame builder.
package uart_pkg;

    localparam int unsigned FRAME_W = 12;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned DATA_W  = 8;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        BUSY  = 3'd3,
        GAP   = 3'd4
    } tx_state_e;

    // Line configuration captured at the pop edge.
    typedef struct packed {
        logic [1:0] parity_type;
        logic       stop_bits;
        logic       data_length;
    } frame_cfg_t;

    // Built frame: serial bits (bit 0 first) and number of valid bits.
    typedef struct packed {
        logic [FRAME_W-1:0] bits;
        logic [LEN_W-1:0]   len;
    } frame_t;

    // Start bit, data LSB first, optional parity, stop bits; everything
    // above the frame is idle-high.
    function automatic frame_t build_frame(input logic [DATA_W-1:0] data,
                                           input frame_cfg_t        cfg);
        frame_t            f;
        logic [DATA_W-1:0] dmask;
        logic              par_en;
        logic              par_bit;
        logic [LEN_W-1:0]  par_pos;

        dmask   = cfg.data_length ? data : {1'b0, data[6:0]};
        par_en  = (cfg.parity_type == PAR_ODD) || (cfg.parity_type == PAR_EVEN);
        par_bit = (cfg.parity_type == PAR_ODD) ? ~^dmask : ^dmask;
        par_pos = cfg.data_length ? LEN_W'(9) : LEN_W'(8);

        f.bits      = '1;
        f.bits[0]   = 1'b0;
        // In 7-bit mode bit 8 stays high unless parity lands there.
        f.bits[8:1] = cfg.data_length ? data : {1'b1, data[6:0]};
        if (par_en) begin
            f.bits[par_pos] = par_bit;
        end

        f.len = LEN_W'(1)
              + (cfg.data_length ? LEN_W'(8) : LEN_W'(7))
              + LEN_W'(par_en)
              + (cfg.stop_bits ? LEN_W'(2) : LEN_W'(1));
        return f;
    endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Host byte stream into the UART transmit controller.
//   data_in    : byte to transmit
//   data_valid : host offers data_in
//   data_ready : controller FIFO can accept
interface uart_tx_frame_ctrl_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with separate occupancy counter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push      : write wr_data (ignored when full)
//   wr_data   : byte to store
//   pop       : advance read pointer (ignored when empty)
//   rd_data   : head entry, valid while not empty
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : current occupancy
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_en_c;
    logic              rd_en_c;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_en_c = push && !full;
    assign rd_en_c = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({wr_en_c, rd_en_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: buffers host bytes, builds each into a
// serial frame at pop time and hands it to the shift stage.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   host         : byte stream (data_in / data_valid / data_ready)
//   parity_type  : 00/11 none, 01 odd, 10 even (sampled at pop)
//   stop_bits    : 0 one stop bit, 1 two (sampled at pop)
//   data_length  : 0 seven data bits, 1 eight (sampled at pop)
//   frame_out    : frame to serialise, bit 0 first
//   frame_len    : valid bits in frame_out
//   send         : shift stage owns the frame
//   tx_done      : shift stage idle/finished (1) or transmitting (0)
//   tx_busy      : controller not in IDLE
//   fifo_count   : FIFO occupancy
module uart_tx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_frame_ctrl_if.slave     host,
    input  logic [1:0]              parity_type,
    input  logic                    stop_bits,
    input  logic                    data_length,
    output logic [FRAME_W-1:0]      frame_out,
    output logic [LEN_W-1:0]        frame_len,
    output logic                    send,
    input  logic                    tx_done,
    output logic                    tx_busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    tx_state_e          state_q;
    tx_state_e          state_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_head;
    logic               push_c;
    logic               pop_c;
    frame_cfg_t         cfg_c;
    frame_t             built_c;
    logic [FRAME_W-1:0] frame_d;
    logic [LEN_W-1:0]   len_d;
    logic               send_d;
    logic               busy_d;

    // Ready depends on the registered count only, so a same-cycle pop
    // does not open an extra slot.
    assign host.data_ready = !fifo_full && !rst;
    assign push_c          = host.data_valid && host.data_ready;

    assign cfg_c = '{parity_type: parity_type,
                     stop_bits:   stop_bits,
                     data_length: data_length};
    assign built_c = build_frame(fifo_head, cfg_c);

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .wr_data (host.data_in),
        .pop     (pop_c),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            frame_out <= '1;
            frame_len <= '0;
            send      <= 1'b0;
            tx_busy   <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_out <= frame_d;
            frame_len <= len_d;
            send      <= send_d;
            tx_busy   <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!fifo_empty) state_d = LOAD;
            LOAD:    state_d = START;
            START:   if (!tx_done) state_d = BUSY;
            BUSY:    if (tx_done) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: pop and frame capture in IDLE, send follows the
    // states in which the shift stage owns the frame.
    always_comb begin
        pop_c   = 1'b0;
        frame_d = frame_out;
        len_d   = frame_len;
        send_d  = (state_d == START) || (state_d == BUSY);
        busy_d  = (state_d != IDLE);
        if ((state_q == IDLE) && !fifo_empty) begin
            pop_c   = 1'b1;
            frame_d = built_c.bits;
            len_d   = built_c.len;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl: expected frames are queued as
// bytes are accepted and compared at each rising edge of send.
module tb_uart_tx_frame_ctrl;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned SHIFT_CYC = 3;
    localparam int unsigned WAIT_MAX  = 2000;

    logic        clk;
    logic        rst;
    logic [1:0]  parity_type;
    logic        stop_bits;
    logic        data_length;
    logic [11:0] frame_out;
    logic [3:0]  frame_len;
    logic        send;
    logic        tx_done;
    logic        tx_busy;
    logic [$clog2(DEPTH):0] fifo_count;

    uart_tx_frame_ctrl_if bus();

    uart_tx_frame_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (bus),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .data_length (data_length),
        .frame_out   (frame_out),
        .frame_len   (frame_len),
        .send        (send),
        .tx_done     (tx_done),
        .tx_busy     (tx_busy),
        .fifo_count  (fifo_count)
    );

    int          checks;
    int          failures;
    int          frames_seen;
    bit          stall;
    logic [15:0] sb_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference frame as {len, frame}: idle-high field shifted above the
    // payload, data and parity OR'd in.
    function automatic logic [15:0] model(input logic [7:0] d, input logic [1:0] pt,
                                          input logic sb, input logic dl);
        int          n;
        int          p;
        int          s;
        logic [11:0] dm;
        logic        pb;
        logic [11:0] f;
        n  = dl ? 8 : 7;
        p  = (pt == 2'b01 || pt == 2'b10) ? 1 : 0;
        s  = sb ? 2 : 1;
        dm = 12'(d) & ((12'd1 << n) - 12'd1);
        pb = (pt == 2'b01) ? ~^dm : ^dm;
        f  = (12'hFFF << (n + 1 + p)) | (dm << 1) | ((p != 0) ? (12'(pb) << (n + 1)) : 12'h000);
        return {4'(1 + n + p + s), f};
    endfunction

    // Shift-stage model: drops tx_done while transmitting; stall holds it low.
    initial begin
        int  cnt;
        bit  active;
        tx_done = 1'b1;
        active  = 1'b0;
        cnt     = 0;
        forever begin
            @(negedge clk);
            if (!send) begin
                tx_done = 1'b1;
                active  = 1'b0;
            end else if (!active) begin
                tx_done = 1'b0;
                active  = 1'b1;
                cnt     = SHIFT_CYC;
            end else if (!stall) begin
                if (cnt > 0) cnt--;
                else tx_done = 1'b1;
            end
        end
    end

    // Scoreboard monitor: every new frame must match the queue head.
    initial begin
        logic        prev;
        logic [15:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (send && !prev) begin
                frames_seen++;
                chk("sb_pending", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("sb_frame", frame_out, e[11:0]);
                    chk("sb_len", frame_len, e[15:12]);
                end
            end
            prev = send;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic set_cfg(input logic [1:0] pt, input logic sb, input logic dl);
        parity_type = pt;
        stop_bits   = sb;
        data_length = dl;
    endtask

    // Offer a byte, wait for acceptance, queue its expected frame.
    task automatic push_byte(input logic [7:0] d);
        int n;
        @(negedge clk);
        bus.data_in    = d;
        bus.data_valid = 1'b1;
        n = 0;
        while (!bus.data_ready && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", bus.data_ready, 1);
        sb_q.push_back(model(d, parity_type, stop_bits, data_length));
        @(posedge clk);
        #1 bus.data_valid = 1'b0;
    endtask

    task automatic wait_rise();
        int n;
        n = 0;
        while (send && n < WAIT_MAX) begin @(negedge clk); n++; end
        while (!send && n < WAIT_MAX) begin @(negedge clk); n++; end
        chk("send_rise", send, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((tx_busy || send || fifo_count != 0 || sb_q.size() != 0) && n < WAIT_MAX);
        chk("idle_busy", tx_busy, 0);
        chk("idle_cnt", fifo_count, 0);
    endtask

    initial begin
        int base;
        checks         = 0;
        failures       = 0;
        frames_seen    = 0;
        stall          = 1'b0;
        rst            = 1'b1;
        bus.data_in    = 8'h00;
        bus.data_valid = 1'b0;
        set_cfg(2'b00, 1'b0, 1'b1);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_send", send, 0);
        chk("rst_frame", frame_out, 12'hFFF);
        chk("rst_len", frame_len, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_rdy", bus.data_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", bus.data_ready, 1);

        // 8N1 0xA5 with latency from the push edge
        set_cfg(2'b00, 1'b0, 1'b1);
        push_byte(8'hA5);
        @(negedge clk);
        chk("lat_e0_send", send, 0);
        @(negedge clk);
        chk("lat_e1_send", send, 0);
        chk("8n1_frame", frame_out, 12'hF4A);
        chk("8n1_len", frame_len, 10);
        @(negedge clk);
        chk("lat_e2_send", send, 1);
        wait_idle();

        // 8O2 0x03
        set_cfg(2'b01, 1'b1, 1'b1);
        push_byte(8'h03);
        wait_rise();
        chk("8o2_frame", frame_out, 12'hE06);
        chk("8o2_len", frame_len, 12);
        wait_idle();

        // 7E1 0xFF
        set_cfg(2'b10, 1'b0, 1'b0);
        push_byte(8'hFF);
        wait_rise();
        chk("7e1_frame", frame_out, 12'hFFE);
        chk("7e1_len", frame_len, 10);
        wait_idle();

        // Random configurations, short bursts
        for (int i = 0; i < 8; i++) begin
            set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                push_byte(8'($urandom_range(0, 255)));
            end
            wait_idle();
        end

        // Backpressure: stalled shift stage, FIFO fills to DEPTH
        set_cfg(2'b00, 1'b0, 1'b1);
        stall = 1'b1;
        base  = frames_seen;
        push_byte(8'h10);
        wait_rise();
        push_byte(8'h21);
        push_byte(8'h32);
        push_byte(8'h43);
        push_byte(8'h54);
        @(negedge clk);
        bus.data_in    = 8'h65;
        bus.data_valid = 1'b1;
        #1;
        chk("bp_rdy", bus.data_ready, 0);
        chk("bp_cnt", fifo_count, 4);
        repeat (3) @(negedge clk);
        chk("bp_rdy_hold", bus.data_ready, 0);
        chk("bp_cnt_hold", fifo_count, 4);
        chk("bp_send_hold", send, 1);
        bus.data_valid = 1'b0;
        stall = 1'b0;
        wait_idle();
        chk("bp_frames", frames_seen - base, 5);

        // Config change while BUSY only affects the next frame
        stall = 1'b1;
        set_cfg(2'b00, 1'b0, 1'b1);
        push_byte(8'h83);
        wait_rise();
        repeat (2) @(negedge clk);
        set_cfg(2'b10, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("cfg_hold_frame", frame_out, 12'hF06);
        chk("cfg_hold_len", frame_len, 10);
        push_byte(8'h83);
        stall = 1'b0;
        wait_rise();
        chk("cfg_new_frame", frame_out, 12'hE06);
        wait_idle();

        // Reset in the middle of a frame with bytes queued
        stall = 1'b1;
        set_cfg(2'b00, 1'b0, 1'b1);
        push_byte(8'h11);
        wait_rise();
        push_byte(8'h22);
        push_byte(8'h33);
        @(negedge clk);
        chk("mid_cnt", fifo_count, 2);
        rst = 1'b1;
        #1;
        chk("mid_rdy_in_rst", bus.data_ready, 0);
        @(negedge clk);
        chk("mid_send", send, 0);
        chk("mid_frame", frame_out, 12'hFFF);
        chk("mid_cnt_flush", fifo_count, 0);
        chk("mid_busy", tx_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        stall = 1'b0;
        #1;
        chk("mid_rdy_after", bus.data_ready, 1);
        repeat (6) @(negedge clk);
        chk("mid_quiet_send", send, 0);
        chk("mid_quiet_busy", tx_busy, 0);

        // Recovery after reset
        set_cfg(2'b01, 1'b0, 1'b1);
        push_byte(8'h5A);
        wait_idle();
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
